audio_pkt_sched: RTL and testbench

- Read-side controller for the audio-sample packet FIFO (32-bit words, 1024 deep, asynchronous FIFO, no output register).
- Watches the FIFO read water level and decides when to launch a UDP transmit: a full packet when PKT_WORDS words are buffered, or a short flush packet after FLUSH_TIMEOUT idle cycles.
- Drives the FIFO read enable from the UDP core's word requests and counts words out.
- Sits between the FIFO read port and the UDP transmit core, in the UDP transmit clock domain.

---
 rtl/audio_pkt_pkg.sv | 21 ++
 rtl/audio_pkt_flush_timer.sv | 32 +++
 rtl/audio_pkt_sched.sv | 154 +++++++++++++++
 tb/tb_audio_pkt_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkt_pkg.sv
// Shared types and constants for the audio packet scheduler.
// State encodings, word/byte conversion and default packet sizing.
package audio_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } pkt_state_t;

    localparam int unsigned BYTES_PER_WORD    = 4;
    localparam int unsigned DEF_PKT_WORDS     = 256;
    localparam int unsigned DEF_FLUSH_TIMEOUT = 50000;

    function automatic logic [15:0] words_to_bytes(input logic [15:0] words);
        return words * 16'(BYTES_PER_WORD);
    endfunction

endpackage

// File: rtl/audio_pkt_flush_timer.sv
// Idle timer for a partially filled FIFO: counts while enabled and saturates
// at TIMEOUT-1, which is reported on expired.
module audio_pkt_flush_timer
    import audio_pkt_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_FLUSH_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned     CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TC   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (clear) begin
            flush_cnt <= '0;
        end else if (count_en && (flush_cnt != TC)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign expired = (flush_cnt == TC);

endmodule

// File: rtl/audio_pkt_sched.sv
// Read-side scheduler between the audio sample FIFO and the UDP transmit core:
// launches full or timed-out flush packets and paces FIFO pops to word requests.
module audio_pkt_sched
    import audio_pkt_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 10,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned PKT_WORDS     = DEF_PKT_WORDS,
    parameter int unsigned FLUSH_TIMEOUT = DEF_FLUSH_TIMEOUT,
    parameter int unsigned IFG_CYCLES    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [ADDR_WIDTH:0]   fifo_rd_water_level,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  tx_start_en,
    output logic [15:0]           tx_byte_num,
    input  logic                  tx_req,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_done,
    output logic                  busy,
    output logic                  underflow,
    output logic [15:0]           pkt_cnt
);

    localparam int unsigned     LVL_W    = ADDR_WIDTH + 1;
    localparam int unsigned     GAP_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [LVL_W-1:0] PKT_LVL = LVL_W'(PKT_WORDS);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    pkt_state_t       state_q, state_d;
    logic [LVL_W-1:0] words_left_q, words_left_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [15:0]      byte_num_q, byte_num_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;
    logic             underflow_q, underflow_d;
    logic             pop, start_pulse;
    logic             rd_en_q;
    logic [DATA_WIDTH-1:0] data_hold_q;
    logic             flush_expired, flush_clear, flush_count_en;

    assign flush_clear    = (state_q != ST_IDLE) || fifo_empty || !enable;
    assign flush_count_en = (fifo_rd_water_level < PKT_LVL);

    audio_pkt_flush_timer #(
        .TIMEOUT (FLUSH_TIMEOUT)
    ) u_flush_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (flush_clear),
        .count_en (flush_count_en),
        .expired  (flush_expired)
    );

    // The packet length is loaded straight into words_left on leaving IDLE,
    // so no separate pkt_words register is kept.
    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        gap_cnt_d    = gap_cnt_q;
        byte_num_d   = byte_num_q;
        pkt_cnt_d    = pkt_cnt_q;
        underflow_d  = underflow_q;
        pop          = 1'b0;
        start_pulse  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && (fifo_rd_water_level >= PKT_LVL)) begin
                    words_left_d = PKT_LVL;
                    byte_num_d   = words_to_bytes(16'(PKT_LVL));
                    state_d      = ST_START;
                end else if (enable && !fifo_empty && flush_expired) begin
                    words_left_d = fifo_rd_water_level;
                    byte_num_d   = words_to_bytes(16'(fifo_rd_water_level));
                    state_d      = ST_START;
                end
            end
            ST_START: begin
                start_pulse = 1'b1;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                pop = tx_req && (words_left_q != '0);
                if (pop) begin
                    words_left_d = words_left_q - LVL_W'(1);
                    if (fifo_empty) begin
                        underflow_d = 1'b1;
                    end
                end
                if (tx_done) begin
                    words_left_d = '0;
                    pkt_cnt_d    = pkt_cnt_q + 16'd1;
                    gap_cnt_d    = '0;
                    state_d      = ST_GAP;
                end else if (words_left_d == '0) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            words_left_q <= '0;
            gap_cnt_q    <= '0;
            byte_num_q   <= '0;
            pkt_cnt_q    <= '0;
            underflow_q  <= 1'b0;
            rd_en_q      <= 1'b0;
            data_hold_q  <= '0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            gap_cnt_q    <= gap_cnt_d;
            byte_num_q   <= byte_num_d;
            pkt_cnt_q    <= pkt_cnt_d;
            underflow_q  <= underflow_d;
            rd_en_q      <= pop;
            if (rd_en_q) begin
                data_hold_q <= fifo_rd_data;
            end
        end
    end

    // FIFO data is passed through on the cycle after a pop and held otherwise.
    assign tx_data     = rd_en_q ? fifo_rd_data : data_hold_q;
    assign fifo_rd_en  = pop;
    assign tx_start_en = start_pulse;
    assign tx_byte_num = byte_num_q;
    assign busy        = (state_q != ST_IDLE);
    assign underflow   = underflow_q;
    assign pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_audio_pkt_sched.sv
// Directed bench for audio_pkt_sched with a behavioural FIFO and UDP core;
// FLUSH_TIMEOUT is shortened to 100 cycles.
module tb_audio_pkt_sched;

    logic        clk_tb = 1'b0;
    logic        tb_rst = 1'b0;
    logic        enable = 1'b0;
    logic [10:0] fifo_rd_water_level;
    logic        fifo_empty;
    logic [31:0] fifo_rd_data = '0;
    logic        fifo_rd_en;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic        tx_req = 1'b0;
    logic [31:0] tx_data;
    logic        tx_done = 1'b0;
    logic        busy;
    logic        underflow;
    logic [15:0] pkt_cnt;

    int n_vec = 0;
    int n_err = 0;

    audio_pkt_sched #(
        .ADDR_WIDTH    (10),
        .DATA_WIDTH    (32),
        .PKT_WORDS     (256),
        .FLUSH_TIMEOUT (100),
        .IFG_CYCLES    (16)
    ) dut (
        .clk                 (clk_tb),
        .rst_n               (tb_rst),
        .enable              (enable),
        .fifo_rd_water_level (fifo_rd_water_level),
        .fifo_empty          (fifo_empty),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_rd_en          (fifo_rd_en),
        .tx_start_en         (tx_start_en),
        .tx_byte_num         (tx_byte_num),
        .tx_req              (tx_req),
        .tx_data             (tx_data),
        .tx_done             (tx_done),
        .busy                (busy),
        .underflow           (underflow),
        .pkt_cnt             (pkt_cnt)
    );

    always #5 clk_tb = ~clk_tb;

    // FIFO model: write side owned by tasks, read side by the clocked block.
    logic [31:0] mem [0:4095];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    logic force_empty = 1'b0;
    int   cyc = 0;
    int   pop_cnt = 0;
    logic pop_q = 1'b0;

    assign fifo_empty          = force_empty || (wr_ptr == rd_ptr);
    assign fifo_rd_water_level = force_empty ? 11'd0 : 11'(wr_ptr - rd_ptr);

    always @(posedge clk_tb) begin
        cyc   <= cyc + 1;
        pop_q <= fifo_rd_en;
        if (fifo_rd_en) pop_cnt <= pop_cnt + 1;
        if (fifo_rd_en && !fifo_empty) begin
            fifo_rd_data <= mem[rd_ptr % 4096];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    int          start_q [$];
    logic [15:0] bytes_q [$];
    logic [31:0] rx_q    [$];
    int          done_q  [$];

    always @(negedge clk_tb) begin
        if (tx_start_en) begin
            start_q.push_back(cyc);
            bytes_q.push_back(tx_byte_num);
        end
        if (pop_q) rx_q.push_back(tx_data);
    end

    // UDP core model: requests every word back to back, then signals done.
    int req_left = 0;
    int done_wait = 0;
    always @(negedge clk_tb) begin
        if (!tb_rst) begin
            req_left = 0; done_wait = 0; tx_req = 1'b0; tx_done = 1'b0;
        end else begin
            tx_done = 1'b0;
            if (tx_start_en) begin
                req_left = int'(tx_byte_num) / 4;
                tx_req   = 1'b0;
            end else if (req_left > 0) begin
                tx_req   = 1'b1;
                req_left = req_left - 1;
                if (req_left == 0) done_wait = 4;
            end else begin
                tx_req = 1'b0;
                if (done_wait > 0) begin
                    done_wait = done_wait - 1;
                    if (done_wait == 0) begin
                        tx_done = 1'b1;
                        done_q.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic load_words(input int n, input int first_val);
        for (int i = 0; i < n; i++) mem[(wr_ptr + i) % 4096] = 32'(first_val + i);
        wr_ptr = wr_ptr + n;
    endtask

    task automatic drain_fifo();
        wr_ptr = rd_ptr;
    endtask

    task automatic wait_pkt(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_tb);
            if (int'(pkt_cnt) == target && !busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_start(input int s0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_tb);
            if (start_q.size() > s0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        tb_rst = 1'b0; enable = 1'b0;
        repeat (2) @(negedge clk_tb);
        n_vec++;
        if ({fifo_rd_en, tx_start_en, busy, underflow} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 0000", {fifo_rd_en, tx_start_en, busy, underflow});
        end
        n_vec++;
        if (tx_byte_num !== 16'd0) begin n_err++; $display("FAIL reset_byte_num: got %0d expected 0", tx_byte_num); end
        n_vec++;
        if (pkt_cnt !== 16'd0) begin n_err++; $display("FAIL reset_pkt_cnt: got %0d expected 0", pkt_cnt); end
        n_vec++;
        if (tx_data !== 32'd0) begin n_err++; $display("FAIL reset_tx_data: got %0h expected 0", tx_data); end
        tb_rst = 1'b1;
        repeat (2) @(negedge clk_tb);
    endtask

    task automatic test_full_packet();
        int s0, p0, r0, errs;
        bit ok;
        s0 = start_q.size(); p0 = pop_cnt; r0 = rx_q.size();
        enable = 1'b1;
        load_words(300, 1);
        wait_pkt(1, 1500, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL full_done: pkt_cnt=%0d busy=%b expected 1/0", pkt_cnt, busy); end
        n_vec++;
        if (start_q.size() - s0 != 1) begin n_err++; $display("FAIL full_starts: got %0d expected 1", start_q.size() - s0); end
        n_vec++;
        if (bytes_q.size() <= s0 || bytes_q[s0] !== 16'd1024) begin
            n_err++; $display("FAIL full_byte_num: got %0d expected 1024", (bytes_q.size() > s0) ? bytes_q[s0] : 16'hffff);
        end
        n_vec++;
        if (pop_cnt - p0 != 256) begin n_err++; $display("FAIL full_pops: got %0d expected 256", pop_cnt - p0); end
        errs = 0;
        for (int i = 0; i < 256; i++)
            if (r0 + i >= rx_q.size() || rx_q[r0 + i] !== 32'(i + 1)) errs++;
        n_vec++;
        if (errs != 0) begin n_err++; $display("FAIL full_data: %0d bad words, expected sequence 1..256", errs); end
        n_vec++;
        if (wr_ptr - rd_ptr != 44) begin n_err++; $display("FAIL full_remaining: got %0d expected 44", wr_ptr - rd_ptr); end
        drain_fifo();
    endtask

    task automatic test_flush();
        int s0, p0, l0, dt;
        bit ok;
        repeat (5) @(negedge clk_tb);
        s0 = start_q.size(); p0 = pop_cnt; l0 = cyc;
        load_words(10, 1001);
        wait_start(s0, 300, ok);
        dt = ok ? start_q[s0] - l0 : -1;
        n_vec++;
        if (dt != 100) begin n_err++; $display("FAIL flush_delay: got %0d expected 100", dt); end
        n_vec++;
        if (!ok || bytes_q[s0] !== 16'd40) begin
            n_err++; $display("FAIL flush_byte_num: got %0d expected 40", ok ? bytes_q[s0] : 16'hffff);
        end
        wait_pkt(2, 500, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL flush_done: pkt_cnt=%0d expected 2", pkt_cnt); end
        n_vec++;
        if (pop_cnt - p0 != 10) begin n_err++; $display("FAIL flush_pops: got %0d expected 10", pop_cnt - p0); end
        n_vec++;
        if (fifo_empty !== 1'b1) begin n_err++; $display("FAIL flush_fifo_empty: got %b expected 1", fifo_empty); end
    endtask

    task automatic test_back_to_back();
        int s0, d0, p0, r0, errs, gap, fl;
        bit ok;
        repeat (5) @(negedge clk_tb);
        s0 = start_q.size(); d0 = done_q.size(); p0 = pop_cnt; r0 = rx_q.size();
        load_words(600, 1);
        wait_pkt(5, 3000, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL b2b_done: pkt_cnt=%0d expected 5", pkt_cnt); end
        n_vec++;
        if (start_q.size() - s0 != 3) begin n_err++; $display("FAIL b2b_starts: got %0d expected 3", start_q.size() - s0); end
        if (start_q.size() - s0 >= 3 && done_q.size() - d0 >= 2) begin
            gap = start_q[s0 + 1] - done_q[d0];
            fl  = start_q[s0 + 2] - done_q[d0 + 1];
        end else begin
            gap = -1; fl = -1;
        end
        n_vec++;
        if (gap < 17) begin n_err++; $display("FAIL b2b_gap: got %0d expected >= 17", gap); end
        n_vec++;
        if (fl != 117) begin n_err++; $display("FAIL b2b_flush_delay: got %0d expected 117", fl); end
        n_vec++;
        if (bytes_q.size() - s0 < 3 || {bytes_q[s0], bytes_q[s0 + 1], bytes_q[s0 + 2]} !== {16'd1024, 16'd1024, 16'd352}) begin
            n_err++; $display("FAIL b2b_byte_nums: wrong sequence, expected 1024 1024 352");
        end
        n_vec++;
        if (pop_cnt - p0 != 600) begin n_err++; $display("FAIL b2b_pops: got %0d expected 600", pop_cnt - p0); end
        errs = 0;
        for (int i = 0; i < 600; i++)
            if (r0 + i >= rx_q.size() || rx_q[r0 + i] !== 32'(i + 1)) errs++;
        n_vec++;
        if (errs != 0) begin n_err++; $display("FAIL b2b_data: %0d bad words, expected sequence 1..600", errs); end
    endtask

    task automatic test_underflow();
        int p0;
        bit ok, hit;
        repeat (5) @(negedge clk_tb);
        p0 = pop_cnt; hit = 1'b0;
        load_words(300, 1);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_tb);
            if (pop_cnt - p0 >= 128) begin hit = 1'b1; break; end
        end
        force_empty = 1'b1;
        wait_pkt(6, 1000, ok);
        n_vec++;
        if (!hit || !ok) begin n_err++; $display("FAIL uf_done: pkt_cnt=%0d reached_half=%b expected 6/1", pkt_cnt, hit); end
        n_vec++;
        if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_flag: got %b expected 1", underflow); end
        n_vec++;
        if (pop_cnt - p0 != 256) begin n_err++; $display("FAIL uf_pops: got %0d expected 256", pop_cnt - p0); end
        force_empty = 1'b0;
        drain_fifo();
        repeat (20) @(negedge clk_tb);
        n_vec++;
        if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_sticky: got %b expected 1", underflow); end
    endtask

    task automatic test_reset_mid_send();
        int p0, s0, r0, l0, dt, errs;
        bit ok, hit;
        repeat (5) @(negedge clk_tb);
        p0 = pop_cnt; hit = 1'b0;
        load_words(300, 1);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_tb);
            if (pop_cnt - p0 >= 100) begin hit = 1'b1; break; end
        end
        tb_rst = 1'b0;
        @(negedge clk_tb);
        n_vec++;
        if (!hit || {fifo_rd_en, busy, underflow} !== 3'b000) begin
            n_err++; $display("FAIL rst_flags: rd_en/busy/underflow got %b expected 000", {fifo_rd_en, busy, underflow});
        end
        n_vec++;
        if (tx_byte_num !== 16'd0) begin n_err++; $display("FAIL rst_byte_num: got %0d expected 0", tx_byte_num); end
        n_vec++;
        if (pkt_cnt !== 16'd0) begin n_err++; $display("FAIL rst_pkt_cnt: got %0d expected 0", pkt_cnt); end
        n_vec++;
        if (pop_cnt - p0 != 100) begin n_err++; $display("FAIL rst_pops: got %0d expected 100", pop_cnt - p0); end
        @(negedge clk_tb);
        tb_rst = 1'b1;
        s0 = start_q.size(); r0 = rx_q.size(); l0 = cyc;
        load_words(100, 301);
        wait_start(s0, 10, ok);
        dt = ok ? start_q[s0] - l0 : -1;
        n_vec++;
        if (dt < 1 || dt > 3) begin n_err++; $display("FAIL rst_restart: delay %0d expected 1..3", dt); end
        wait_pkt(1, 1000, ok);
        errs = 0;
        for (int i = 0; i < 256; i++)
            if (r0 + i >= rx_q.size() || rx_q[r0 + i] !== 32'(101 + i)) errs++;
        n_vec++;
        if (!ok || errs != 0) begin n_err++; $display("FAIL rst_repacket: pkt_cnt=%0d bad_words=%0d expected 1/0", pkt_cnt, errs); end
        drain_fifo();
    endtask

    task automatic test_enable_gating();
        int s0, p0, e0, dt;
        bit ok;
        enable = 1'b0;
        repeat (5) @(negedge clk_tb);
        s0 = start_q.size(); p0 = pop_cnt;
        load_words(500, 1);
        repeat (200) @(negedge clk_tb);
        n_vec++;
        if (start_q.size() != s0 || busy !== 1'b0) begin
            n_err++; $display("FAIL en_gated: starts=%0d busy=%b expected 0/0", start_q.size() - s0, busy);
        end
        e0 = cyc;
        enable = 1'b1;
        wait_start(s0, 10, ok);
        dt = ok ? start_q[s0] - e0 : -1;
        n_vec++;
        if (dt < 1 || dt > 2) begin n_err++; $display("FAIL en_start_delay: got %0d expected 1..2", dt); end
        n_vec++;
        if (!ok || bytes_q[s0] !== 16'd1024) begin
            n_err++; $display("FAIL en_byte_num: got %0d expected 1024", ok ? bytes_q[s0] : 16'hffff);
        end
        wait_pkt(2, 1000, ok);
        n_vec++;
        if (!ok || pop_cnt - p0 != 256) begin n_err++; $display("FAIL en_packet: pkt_cnt=%0d pops=%0d expected 2/256", pkt_cnt, pop_cnt - p0); end
        drain_fifo();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(negedge clk_tb);
        test_reset();
        test_full_packet();
        test_flush();
        test_back_to_back();
        test_underflow();
        test_reset_mid_send();
        test_enable_gating();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
